// File: rtl/wed_fetch_pkg.sv
// CAPI constants, response codes and fetch states.
// Shared by the WED fetch unit and its parity helper.
package wed_fetch_pkg;

  localparam logic [7:0]  TAG         = 8'h01;
  localparam logic [1:0]  MAX_RETRIES = 2'd3;
  localparam logic [12:0] READ_CL_NA  = 13'h0A00;
  localparam logic [11:0] WED_SIZE    = 12'd128;
  localparam logic [7:0]  LOCAL_FAULT = 8'hFF;

  typedef enum logic [7:0] {
    RSP_DONE    = 8'h00,
    RSP_AERROR  = 8'h01,
    RSP_DERROR  = 8'h03,
    RSP_NLOCK   = 8'h04,
    RSP_NRES    = 8'h05,
    RSP_FLUSHED = 8'h06,
    RSP_FAULT   = 8'h07,
    RSP_FAILED  = 8'h08,
    RSP_PAGED   = 8'h0A,
    RSP_CONTEXT = 8'h0B
  } rsp_code_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERROR
  } fetch_state_e;

  // Any doubleword whose received parity differs from the
  // locally generated odd parity is a data fault.
  function automatic logic dw_parity_fault(
    input logic [7:0] expect_par,
    input logic [7:0] got_par
  );
    return |(expect_par ^ got_par);
  endfunction

endpackage

// File: rtl/wed_fetch_if.sv
// PSL command / buffer-write / response bundle.
// master = accelerator side issuing commands.
interface wed_fetch_if;

  logic [7:0]   room;
  logic         cmd_valid;
  logic [7:0]   cmd_tag;
  logic         cmd_tag_parity;
  logic [12:0]  cmd_code;
  logic         cmd_code_parity;
  logic [63:0]  cmd_address;
  logic         cmd_address_parity;
  logic [11:0]  cmd_size;
  logic         bw_valid;
  logic [7:0]   bw_tag;
  logic [5:0]   bw_address;
  logic [511:0] bw_data;
  logic [7:0]   bw_parity;
  logic         rsp_valid;
  logic [7:0]   rsp_tag;
  logic [7:0]   rsp_code;

  modport master (
    input  room,
    output cmd_valid, cmd_tag, cmd_tag_parity,
    output cmd_code, cmd_code_parity,
    output cmd_address, cmd_address_parity,
    output cmd_size,
    input  bw_valid, bw_tag, bw_address,
    input  bw_data, bw_parity,
    input  rsp_valid, rsp_tag, rsp_code
  );

  modport slave (
    output room,
    input  cmd_valid, cmd_tag, cmd_tag_parity,
    input  cmd_code, cmd_code_parity,
    input  cmd_address, cmd_address_parity,
    input  cmd_size,
    output bw_valid, bw_tag, bw_address,
    output bw_data, bw_parity,
    output rsp_valid, rsp_tag, rsp_code
  );

endinterface

// File: rtl/wed_fetch_odd_parity.sv
// Odd parity generator: output makes total ones count odd.
// Reused for tag, opcode, address and data doublewords.
module wed_fetch_odd_parity #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_o
);

  assign parity_o = ~^data_i;

endmodule

// File: rtl/wed_fetch.sv
// Fetches the 128-byte WED over PSL on job START.
// One READ_CL_NA in flight; retries on PAGED/FLUSHED.
module wed_fetch
  import wed_fetch_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [63:0]    wed_address,
  wed_fetch_if.master    psl,
  output logic [1023:0]  wed,
  output logic           wed_valid,
  output logic           busy,
  output logic           error,
  output logic [7:0]     error_code
);

  fetch_state_e state_q, state_d;
  logic [63:0]  addr_q, addr_d;
  logic [1:0]   retries_q, retries_d;
  logic [1:0]   half_q, half_d;
  logic         pfault_q, pfault_d;
  logic [7:0]   ecode_q, ecode_d;
  logic         cmd_valid_q, cmd_valid_d;
  logic [7:0]   cmd_tag_q, cmd_tag_d;
  logic         cmd_tpar_q, cmd_tpar_d;
  logic [12:0]  cmd_code_q, cmd_code_d;
  logic         cmd_cpar_q, cmd_cpar_d;
  logic [63:0]  cmd_addr_q, cmd_addr_d;
  logic         cmd_apar_q, cmd_apar_d;
  logic [11:0]  cmd_size_q, cmd_size_d;
  logic [1023:0] wed_q;

  logic         tag_par;
  logic         code_par;
  logic         addr_par;
  logic [7:0]   exp_par;
  logic         bw_hit;
  logic         rsp_hit;
  logic [1:0]   half_wr;
  logic [1:0]   half_now;
  logic         pf_now;
  logic         unused_bw;

  assign unused_bw = ^psl.bw_address[5:1];

  wed_fetch_odd_parity #(.WIDTH(8)) u_tag_par (
    .data_i   (TAG),
    .parity_o (tag_par)
  );

  wed_fetch_odd_parity #(.WIDTH(13)) u_code_par (
    .data_i   (READ_CL_NA),
    .parity_o (code_par)
  );

  wed_fetch_odd_parity #(.WIDTH(64)) u_addr_par (
    .data_i   (addr_q),
    .parity_o (addr_par)
  );

  for (genvar i = 0; i < 8; i++) begin : g_dw
    wed_fetch_odd_parity #(.WIDTH(64)) u_dw_par (
      .data_i   (psl.bw_data[64*i +: 64]),
      .parity_o (exp_par[i])
    );
  end

  assign bw_hit  = psl.bw_valid && (psl.bw_tag == TAG)
                && (state_q == S_WAIT);
  assign rsp_hit = psl.rsp_valid && (psl.rsp_tag == TAG)
                && (state_q == S_WAIT);

  // A same-cycle write is folded in before the response is judged.
  assign half_wr  = bw_hit ? (psl.bw_address[0] ? 2'b10 : 2'b01)
                           : 2'b00;
  assign half_now = half_q | half_wr;
  assign pf_now   = pfault_q
                  | (bw_hit && dw_parity_fault(exp_par, psl.bw_parity));

  // Next-state and command-field decode for the fetch FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    retries_d   = retries_q;
    half_d      = half_now;
    pfault_d    = pf_now;
    ecode_d     = ecode_q;
    cmd_valid_d = 1'b0;
    cmd_tag_d   = cmd_tag_q;
    cmd_tpar_d  = cmd_tpar_q;
    cmd_code_d  = cmd_code_q;
    cmd_cpar_d  = cmd_cpar_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_apar_d  = cmd_apar_q;
    cmd_size_d  = cmd_size_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          addr_d    = wed_address;
          retries_d = 2'd0;
          half_d    = 2'b00;
          pfault_d  = 1'b0;
          ecode_d   = 8'h00;
          if (wed_address[6:0] != 7'd0) begin
            state_d = S_ERROR;
            ecode_d = LOCAL_FAULT;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (psl.room != 8'd0) begin
          cmd_valid_d = 1'b1;
          cmd_tag_d   = TAG;
          cmd_tpar_d  = tag_par;
          cmd_code_d  = READ_CL_NA;
          cmd_cpar_d  = code_par;
          cmd_addr_d  = addr_q;
          cmd_apar_d  = addr_par;
          cmd_size_d  = WED_SIZE;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_hit) begin
          if (psl.rsp_code == RSP_DONE) begin
            if ((half_now == 2'b11) && !pf_now) begin
              state_d = S_DONE;
            end else begin
              state_d = S_ERROR;
              ecode_d = LOCAL_FAULT;
            end
          end else if ((psl.rsp_code == RSP_PAGED)
                    || (psl.rsp_code == RSP_FLUSHED)) begin
            if (retries_q < MAX_RETRIES) begin
              retries_d = retries_q + 2'd1;
              half_d    = 2'b00;
              state_d   = S_ISSUE;
            end else begin
              state_d = S_ERROR;
              ecode_d = psl.rsp_code;
            end
          end else begin
            state_d = S_ERROR;
            ecode_d = psl.rsp_code;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and command registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      retries_q   <= '0;
      half_q      <= '0;
      pfault_q    <= 1'b0;
      ecode_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_tag_q   <= '0;
      cmd_tpar_q  <= 1'b0;
      cmd_code_q  <= '0;
      cmd_cpar_q  <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_apar_q  <= 1'b0;
      cmd_size_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      retries_q   <= retries_d;
      half_q      <= half_d;
      pfault_q    <= pfault_d;
      ecode_q     <= ecode_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_tag_q   <= cmd_tag_d;
      cmd_tpar_q  <= cmd_tpar_d;
      cmd_code_q  <= cmd_code_d;
      cmd_cpar_q  <= cmd_cpar_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_apar_q  <= cmd_apar_d;
      cmd_size_q  <= cmd_size_d;
    end
  end

  // WED capture buffer, one half-line per buffer write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wed_q <= '0;
    end else if (bw_hit) begin
      if (psl.bw_address[0]) begin
        wed_q[1023:512] <= psl.bw_data;
      end else begin
        wed_q[511:0] <= psl.bw_data;
      end
    end
  end

  assign psl.cmd_valid          = cmd_valid_q;
  assign psl.cmd_tag            = cmd_tag_q;
  assign psl.cmd_tag_parity     = cmd_tpar_q;
  assign psl.cmd_code           = cmd_code_q;
  assign psl.cmd_code_parity    = cmd_cpar_q;
  assign psl.cmd_address        = cmd_addr_q;
  assign psl.cmd_address_parity = cmd_apar_q;
  assign psl.cmd_size           = cmd_size_q;

  assign wed        = wed_q;
  assign wed_valid  = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);
  assign error_code = ecode_q;
  assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);

endmodule

// File: tb/tb_wed_fetch.sv
// Directed bench for wed_fetch.
// Hand-computed expectations per scenario.
module tb_wed_fetch;

  logic          clock;
  logic          reset;
  logic          start;
  logic [63:0]   wed_address;
  logic [1023:0] wed;
  logic          wed_valid;
  logic          busy;
  logic          error;
  logic [7:0]    error_code;

  wed_fetch_if psl();

  wed_fetch dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .wed_address (wed_address),
    .psl         (psl),
    .wed         (wed),
    .wed_valid   (wed_valid),
    .busy        (busy),
    .error       (error),
    .error_code  (error_code)
  );

  int pass_cnt = 0;
  int total    = 0;
  int cmd_cnt  = 0;

  // dw i of D1 holds i+1, so odd parity per dword is 8'h34.
  // D0 is a repeated 32-bit word, every dword even -> 8'hFF.
  logic [511:0] D0 = {16{32'hDEAD_BEEF}};
  logic [511:0] D1 = {64'd8, 64'd7, 64'd6, 64'd5,
                      64'd4, 64'd3, 64'd2, 64'd1};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (psl.cmd_valid) cmd_cnt <= cmd_cnt + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_start(input logic [63:0] a);
    start = 1'b1;
    wed_address = a;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_cmd(input string nm);
    bit seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (psl.cmd_valid) begin
        seen = 1;
        break;
      end
    end
    total++;
    if (!seen) $display("FAIL %s cmd_valid timeout got=0 exp=1", nm);
    else pass_cnt++;
  endtask

  task automatic send_bw(input logic [7:0] tg, input bit h,
                         input logic [511:0] d, input logic [7:0] p);
    psl.bw_valid = 1'b1;
    psl.bw_tag = tg;
    psl.bw_address = {5'd0, h};
    psl.bw_data = d;
    psl.bw_parity = p;
    tick();
    psl.bw_valid = 1'b0;
  endtask

  task automatic send_rsp(input logic [7:0] tg, input logic [7:0] c);
    psl.rsp_valid = 1'b1;
    psl.rsp_tag = tg;
    psl.rsp_code = c;
    tick();
    psl.rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({wed_valid, error, busy, psl.cmd_valid} !== 4'b0000)
      $display("FAIL reset_flags got=%b exp=0000",
               {wed_valid, error, busy, psl.cmd_valid});
    else pass_cnt++;
    total++;
    if (error_code !== 8'h00 || wed !== '0)
      $display("FAIL reset_data got=%h exp=00", error_code);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    send_start(64'h1000);
    total++;
    if (psl.cmd_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL early_cmd got=%b%b exp=01", psl.cmd_valid, busy);
    else pass_cnt++;
    tick();
    total++;
    if (psl.cmd_valid !== 1'b1)
      $display("FAIL cmd_latency got=%b exp=1", psl.cmd_valid);
    else pass_cnt++;
    total++;
    if (psl.cmd_tag !== 8'h01 || psl.cmd_tag_parity !== 1'b0)
      $display("FAIL cmd_tag got=%h/%b exp=01/0",
               psl.cmd_tag, psl.cmd_tag_parity);
    else pass_cnt++;
    total++;
    if (psl.cmd_code !== 13'h0A00 || psl.cmd_code_parity !== 1'b1)
      $display("FAIL cmd_code got=%h/%b exp=0a00/1",
               psl.cmd_code, psl.cmd_code_parity);
    else pass_cnt++;
    total++;
    if (psl.cmd_address !== 64'h1000 || psl.cmd_address_parity !== 1'b0)
      $display("FAIL cmd_addr got=%h/%b exp=1000/0",
               psl.cmd_address, psl.cmd_address_parity);
    else pass_cnt++;
    total++;
    if (psl.cmd_size !== 12'd128)
      $display("FAIL cmd_size got=%0d exp=128", psl.cmd_size);
    else pass_cnt++;
    tick();
    total++;
    if (psl.cmd_valid !== 1'b0)
      $display("FAIL cmd_pulse got=%b exp=0", psl.cmd_valid);
    else pass_cnt++;
    send_bw(8'h01, 1'b1, D1, 8'h34);
    send_bw(8'h01, 1'b0, D0, 8'hFF);
    total++;
    if (wed_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL pre_done got=%b%b exp=01", wed_valid, busy);
    else pass_cnt++;
    send_rsp(8'h01, 8'h00);
    total++;
    if (wed_valid !== 1'b1 || busy !== 1'b0 || error !== 1'b0)
      $display("FAIL done_flags got=%b%b%b exp=100",
               wed_valid, busy, error);
    else pass_cnt++;
    total++;
    if (wed !== {D1, D0})
      $display("FAIL wed_data got=%h exp=%h", wed[63:0], D0[63:0]);
    else pass_cnt++;
  endtask

  task automatic test_misaligned();
    int base;
    base = cmd_cnt;
    send_start(64'h1040);
    total++;
    if (error !== 1'b1 || error_code !== 8'hFF || wed_valid !== 1'b0)
      $display("FAIL misalign got=%b/%h exp=1/ff", error, error_code);
    else pass_cnt++;
    tick();
    tick();
    total++;
    if (cmd_cnt - base !== 0 || busy !== 1'b0)
      $display("FAIL misalign_cmd got=%0d exp=0", cmd_cnt - base);
    else pass_cnt++;
  endtask

  task automatic test_retry_ok();
    int base;
    base = cmd_cnt;
    send_start(64'h2000);
    wait_cmd("retry1");
    send_rsp(8'h01, 8'h0A);
    wait_cmd("retry2");
    send_rsp(8'h01, 8'h0A);
    wait_cmd("retry3");
    send_bw(8'h01, 1'b0, D0, 8'hFF);
    send_bw(8'h01, 1'b1, D1, 8'h34);
    send_rsp(8'h01, 8'h00);
    total++;
    if (cmd_cnt - base !== 3 || wed_valid !== 1'b1)
      $display("FAIL retry_ok got=%0d/%b exp=3/1",
               cmd_cnt - base, wed_valid);
    else pass_cnt++;
  endtask

  task automatic test_retry_exhaust();
    int base;
    base = cmd_cnt;
    send_start(64'h3000);
    total++;
    if (wed_valid !== 1'b0)
      $display("FAIL restart_clear got=%b exp=0", wed_valid);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      wait_cmd("exhaust");
      send_rsp(8'h01, 8'h0A);
    end
    total++;
    if (cmd_cnt - base !== 4 || error !== 1'b1 || error_code !== 8'h0A)
      $display("FAIL exhaust got=%0d/%b/%h exp=4/1/0a",
               cmd_cnt - base, error, error_code);
    else pass_cnt++;
  endtask

  task automatic test_room_and_tag();
    bit any = 0;
    psl.room = 8'd0;
    send_start(64'h4000);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (psl.cmd_valid) any = 1;
    end
    total++;
    if (any || busy !== 1'b1 || error !== 1'b0)
      $display("FAIL room_hold got=%b/%b exp=0/1", any, busy);
    else pass_cnt++;
    psl.room = 8'd1;
    tick();
    total++;
    if (psl.cmd_valid !== 1'b1 || psl.cmd_address !== 64'h4000)
      $display("FAIL room_issue got=%b/%h exp=1/4000",
               psl.cmd_valid, psl.cmd_address);
    else pass_cnt++;
    send_bw(8'h02, 1'b0, D1, 8'h34);
    send_rsp(8'h02, 8'h00);
    total++;
    if (busy !== 1'b1 || wed_valid !== 1'b0 || error !== 1'b0)
      $display("FAIL foreign_tag got=%b%b%b exp=100",
               busy, wed_valid, error);
    else pass_cnt++;
    send_bw(8'h01, 1'b0, D0, 8'hFF);
    psl.rsp_valid = 1'b1;
    psl.rsp_tag = 8'h01;
    psl.rsp_code = 8'h00;
    send_bw(8'h01, 1'b1, D1, 8'h34);
    psl.rsp_valid = 1'b0;
    total++;
    if (wed_valid !== 1'b1 || wed !== {D1, D0})
      $display("FAIL same_cycle got=%b exp=1", wed_valid);
    else pass_cnt++;
  endtask

  task automatic test_parity_fault();
    send_start(64'h5000);
    wait_cmd("pfault");
    send_bw(8'h01, 1'b0, D0, 8'hFF);
    send_bw(8'h01, 1'b1, D1, 8'h35);
    send_rsp(8'h01, 8'h00);
    total++;
    if (error !== 1'b1 || error_code !== 8'hFF || wed_valid !== 1'b0)
      $display("FAIL pfault got=%b/%h/%b exp=1/ff/0",
               error, error_code, wed_valid);
    else pass_cnt++;
  endtask

  task automatic test_other_code();
    send_start(64'h5080);
    wait_cmd("aerror");
    send_rsp(8'h01, 8'h01);
    total++;
    if (error !== 1'b1 || error_code !== 8'h01)
      $display("FAIL aerror got=%b/%h exp=1/01", error, error_code);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    send_start(64'h6000);
    wait_cmd("abort");
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    send_bw(8'h01, 1'b0, D0, 8'hFF);
    send_bw(8'h01, 1'b1, D1, 8'h34);
    send_rsp(8'h01, 8'h00);
    total++;
    if ({wed_valid, error, busy, psl.cmd_valid} !== 4'b0000)
      $display("FAIL abort_flags got=%b exp=0000",
               {wed_valid, error, busy, psl.cmd_valid});
    else pass_cnt++;
    total++;
    if (error_code !== 8'h00 || wed !== '0 || psl.cmd_address !== 64'h0)
      $display("FAIL abort_data got=%h/%h exp=00/0",
               error_code, psl.cmd_address);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    wed_address = '0;
    psl.room = 8'd1;
    psl.bw_valid = 1'b0;
    psl.bw_tag = '0;
    psl.bw_address = '0;
    psl.bw_data = '0;
    psl.bw_parity = '0;
    psl.rsp_valid = 1'b0;
    psl.rsp_tag = '0;
    psl.rsp_code = '0;
    test_reset();
    test_basic();
    test_misaligned();
    test_retry_ok();
    test_retry_exhaust();
    test_room_and_tag();
    test_parity_fault();
    test_other_code();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
